// File: rtl/dm_line_fill_if.sv
// ============================================================================
// Module   : dm_line_fill_if
// Purpose  : CPU load/store port plus data-memory burst bus for dm_line_fill.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface dm_line_fill_if #(
    parameter int DATA_SIZE    = 32,
    parameter int MEM_SIZE_BIT = 12
);
    logic                    cpu_req;
    logic                    cpu_we;
    logic [MEM_SIZE_BIT-1:0] cpu_addr;
    logic [DATA_SIZE-1:0]    cpu_wdata;
    logic [DATA_SIZE-1:0]    cpu_rdata;
    logic                    cpu_ready;
    logic                    DM_enable;
    logic                    DM_read;
    logic                    DM_write;
    logic [MEM_SIZE_BIT-1:0] DM_address;
    logic [DATA_SIZE-1:0]    DM_in;
    logic [DATA_SIZE-1:0]    DM_out;
    logic                    DM_ack;

    // master: the line-fill controller (it masters the memory bus)
    modport master (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, DM_out, DM_ack,
        output cpu_rdata, cpu_ready, DM_enable, DM_read, DM_write, DM_address, DM_in
    );

    // slave: the CPU and memory environment around the controller
    modport slave (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, DM_out, DM_ack,
        input  cpu_rdata, cpu_ready, DM_enable, DM_read, DM_write, DM_address, DM_in
    );
endinterface

`default_nettype wire

// File: rtl/dm_line_fill.sv
// ============================================================================
// Module   : dm_line_fill
// Purpose  : One-line (16 x 32-bit) read buffer with burst refill and
//            write-through, no-write-allocate stores. Optional macro
//            EARLY_RESTART_EN answers a load as soon as its word arrives.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dm_line_fill #(
    parameter int DATA_SIZE    = 32,
    parameter int MEM_SIZE_BIT = 12,
    parameter int LINE_WORDS   = 16,
    parameter int WAIT_STATE   = 2
) (
    input  logic            clock,
    input  logic            reset,
    dm_line_fill_if.master  bus
);

    localparam int c_OFF_W    = $clog2(LINE_WORDS);
    localparam int c_LINE_LSB = 2 + c_OFF_W;
    localparam int c_TAG_W    = MEM_SIZE_BIT - c_LINE_LSB;
    localparam int c_RET_W    = (WAIT_STATE > 0) ? $clog2(WAIT_STATE + 1) : 1;
    localparam logic [c_OFF_W-1:0] c_LAST = c_OFF_W'(LINE_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_FILL = 3'd3,
        S_RESP = 3'd4
    } state_t;

    state_t               r_state;
    logic [DATA_SIZE-1:0] r_buf [LINE_WORDS];
    logic                 r_valid;
    logic [c_TAG_W-1:0]   r_tag;
    logic [c_OFF_W-1:0]   r_off;
    logic [c_OFF_W-1:0]   r_cnt;
    logic [c_RET_W-1:0]   r_wr_retire;

    logic [c_OFF_W-1:0]   w_off;
    logic [c_TAG_W-1:0]   w_tag;
    logic                 w_hit;
    logic                 w_accept;
    logic                 w_unused;

    assign w_off    = bus.cpu_addr[c_LINE_LSB-1:2];
    assign w_tag    = bus.cpu_addr[MEM_SIZE_BIT-1:c_LINE_LSB];
    assign w_hit    = r_valid && (r_tag == w_tag);
    // The cycle showing cpu_ready still sees the old request; ignore it.
    assign w_accept = bus.cpu_req && !bus.cpu_ready;
    assign w_unused = &{1'b0, bus.cpu_addr[1:0]};

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_valid        <= 1'b0;
            r_tag          <= '0;
            r_off          <= '0;
            r_cnt          <= '0;
            r_wr_retire    <= '0;
            bus.cpu_rdata  <= '0;
            bus.cpu_ready  <= 1'b0;
            bus.DM_enable  <= 1'b0;
            bus.DM_read    <= 1'b0;
            bus.DM_write   <= 1'b0;
            bus.DM_address <= '0;
            bus.DM_in      <= '0;
        end else begin
            bus.cpu_ready  <= 1'b0;
            bus.DM_enable  <= 1'b0;
            bus.DM_read    <= 1'b0;
            bus.DM_write   <= 1'b0;
            bus.DM_address <= '0;
            bus.DM_in      <= '0;
            if (r_wr_retire != '0) begin
                r_wr_retire <= r_wr_retire - 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (bus.cpu_we) begin
                            bus.DM_enable  <= 1'b1;
                            bus.DM_write   <= 1'b1;
                            bus.DM_address <= {bus.cpu_addr[MEM_SIZE_BIT-1:2], 2'b00};
                            bus.DM_in      <= bus.cpu_wdata;
                            bus.cpu_ready  <= 1'b1;
                            r_wr_retire    <= c_RET_W'(WAIT_STATE);
                            if (w_hit) begin
                                r_buf[w_off] <= bus.cpu_wdata;
                            end
                        end else if (w_hit) begin
                            bus.cpu_rdata <= r_buf[w_off];
                            bus.cpu_ready <= 1'b1;
                        end else if (!bus.DM_ack && (r_wr_retire == '0)) begin
                            // Refill waits for any stale burst to drain and for
                            // earlier stores to retire so the line sees them.
                            r_tag   <= w_tag;
                            r_off   <= w_off;
                            r_state <= S_REQ;
                        end
                    end
                end

                S_REQ: begin
                    bus.DM_enable  <= 1'b1;
                    bus.DM_read    <= 1'b1;
                    bus.DM_address <= {r_tag, {c_LINE_LSB{1'b0}}};
                    r_valid        <= 1'b0;
                    r_cnt          <= '0;
                    r_state        <= S_WAIT;
                end

                // r_cnt is zero in WAIT, so the first acked word lands in slot 0.
                S_WAIT, S_FILL: begin
                    if (bus.DM_ack) begin
                        r_buf[r_cnt] <= bus.DM_out;
                        r_cnt        <= r_cnt + 1'b1;
                        r_state      <= S_FILL;
`ifdef EARLY_RESTART_EN
                        if (r_cnt == r_off) begin
                            bus.cpu_rdata <= bus.DM_out;
                            bus.cpu_ready <= 1'b1;
                        end
`endif
                        if (r_cnt == c_LAST) begin
                            r_valid <= 1'b1;
`ifdef EARLY_RESTART_EN
                            r_state <= S_IDLE;
`else
                            r_state <= S_RESP;
`endif
                        end
                    end
                end

                S_RESP: begin
                    bus.cpu_rdata <= r_buf[r_off];
                    bus.cpu_ready <= 1'b1;
                    r_state       <= S_IDLE;
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dm_line_fill.sv
// ============================================================================
// Module   : tb_dm_line_fill
// Purpose  : Directed and random loads/stores against a burst memory model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_dm_line_fill;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    dm_line_fill_if bus ();

    dm_line_fill dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] mem     [1024];
    logic [31:0] ref_mem [1024];
    int          rd_count = 0;
    int          wr_count = 0;
    int          prot_err = 0;
    logic [11:0] last_rd_addr = '0;
    logic [11:0] last_wr_addr = '0;
    logic [31:0] last_wr_data = '0;
    bit          burst_active = 1'b0;
    int          burst_idx    = 0;
    int          burst_base   = 0;
    bit          gap_en       = 1'b0;
    bit          prev_en      = 1'b0;
    bit          prev_rdy     = 1'b0;
    int          cached_base  = -1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Burst memory plus bus-protocol monitor
    initial begin : mem_model
        bus.DM_ack = 1'b0;
        bus.DM_out = '0;
        forever begin
            @(posedge clock); #1;
            if (prev_en && bus.DM_enable) prot_err++;
            if (prev_rdy && bus.cpu_ready) prot_err++;
            if ((bus.DM_enable !== (bus.DM_read | bus.DM_write)) || (bus.DM_read && bus.DM_write))
                prot_err++;
            prev_en  = bus.DM_enable;
            prev_rdy = bus.cpu_ready;
            if (burst_active && !(gap_en && ($urandom_range(0, 3) == 0))) begin
                bus.DM_ack = 1'b1;
                bus.DM_out = mem[burst_base + burst_idx];
                burst_idx++;
                if (burst_idx == 16) burst_active = 1'b0;
            end else begin
                bus.DM_ack = 1'b0;
                bus.DM_out = $urandom;
            end
            if (bus.DM_enable && bus.DM_write) begin
                wr_count++;
                last_wr_addr = bus.DM_address;
                last_wr_data = bus.DM_in;
                mem[bus.DM_address[11:2]] = bus.DM_in;
            end
            if (bus.DM_enable && bus.DM_read) begin
                if (burst_active) prot_err++;
                rd_count++;
                last_rd_addr = bus.DM_address;
                burst_base   = int'(bus.DM_address[11:2]);
                burst_idx    = 0;
                burst_active = 1'b1;
            end
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_ctl"},   {28'd0, bus.cpu_ready, bus.DM_enable, bus.DM_read, bus.DM_write}, 32'd0);
        chk({tag, "_rdata"}, bus.cpu_rdata, 32'd0);
        chk({tag, "_addr"},  {20'd0, bus.DM_address}, 32'd0);
        chk({tag, "_din"},   bus.DM_in, 32'd0);
    endtask

    task automatic settle();
        int n = 0;
        do begin @(posedge clock); #1; n++; end
        while ((burst_active || bus.DM_ack) && n < 100);
    endtask

    task automatic do_access(input bit we, input logic [11:0] addr, input logic [31:0] wd,
                             input string tag, output int lat);
        int          rd0, wr0;
        bit          miss;
        logic [11:0] base;
        logic [31:0] rdata;
        base = addr & 12'hFC0;
        miss = !we && (cached_base != int'(base));
        rd0  = rd_count;
        wr0  = wr_count;
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wd;
        lat = 0;
        do begin @(posedge clock); #1; lat++; end
        while (!bus.cpu_ready && lat < 300);
        chk({tag, "_ready"}, {31'd0, bus.cpu_ready}, 32'd1);
        rdata = bus.cpu_rdata;
        bus.cpu_req = 1'b0;
        bus.cpu_we  = 1'b0;
        @(posedge clock); #1;
        if (we) begin
            ref_mem[addr[11:2]] = wd;
            chk({tag, "_wrcnt"}, wr_count - wr0, 1);
            chk({tag, "_wraddr"}, {20'd0, last_wr_addr}, {20'd0, addr[11:2], 2'b00});
            chk({tag, "_wrdata"}, last_wr_data, wd);
            chk({tag, "_wrlat"}, lat, 1);
        end else begin
            chk({tag, "_data"}, rdata, ref_mem[addr[11:2]]);
            chk({tag, "_rdcnt"}, rd_count - rd0, miss ? 1 : 0);
            if (miss) begin
                chk({tag, "_rdaddr"}, {20'd0, last_rd_addr}, {20'd0, base});
                cached_base = int'(base);
            end else begin
                chk({tag, "_hitlat"}, lat, 1);
            end
        end
        settle();
    endtask

    initial begin : stim
        int          lat, rd0, n;
        logic [11:0] a;
        logic [11:0] lines [4];
        lines[0] = 12'h000; lines[1] = 12'h040; lines[2] = 12'h100; lines[3] = 12'hFC0;
        for (int i = 0; i < 1024; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[12'h048 >> 2]     = 32'hA5A5_0012;
        ref_mem[12'h048 >> 2] = 32'hA5A5_0012;

        reset = 1'b1;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        repeat (3) @(posedge clock);
        #1;
        check_zero("reset");
        reset = 1'b0;
        @(posedge clock); #1;

        do_access(1'b0, 12'h048, 32'h0, "cold_048", lat);
        do_access(1'b0, 12'h07C, 32'h0, "hit_07c", lat);
        do_access(1'b1, 12'h044, 32'hDEAD_BEEF, "st_044", lat);
        do_access(1'b0, 12'h044, 32'h0, "ld_044", lat);
        do_access(1'b1, 12'h304, 32'h1234_5678, "st_miss", lat);
        do_access(1'b0, 12'h04C, 32'h0, "hit_04c", lat);
        do_access(1'b0, 12'h100, 32'h0, "ld_100", lat);
        do_access(1'b0, 12'h048, 32'h0, "ld_048", lat);

        gap_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            a = lines[$urandom_range(0, 3)] | 12'(($urandom_range(0, 15)) << 2);
            do_access($urandom_range(0, 2) == 0, a, $urandom, "rand", lat);
        end

        // Reset in the middle of a burst; the tail of that burst must be drained
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 12'h208;
        n = 0;
        do begin @(posedge clock); #1; n++; end
        while (!(burst_active && burst_idx >= 5) && n < 200);
        reset = 1'b1;
        bus.cpu_req = 1'b0;
        @(posedge clock); #1;
        check_zero("midrst");
        @(posedge clock); #1;
        reset = 1'b0;
        cached_base = -1;
        gap_en = 1'b0;
        do_access(1'b0, 12'h208, 32'h0, "refill_208", lat);
        do_access(1'b0, 12'h23C, 32'h0, "hit_23c", lat);

        // Offset-3 load on a cold line with a gap-free burst
        repeat (4) @(posedge clock);
        #1;
        rd0 = rd_count;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 12'h08C;
        lat = 0;
        do begin @(posedge clock); #1; lat++; end
        while (!bus.cpu_ready && lat < 300);
        chk("er_ready", {31'd0, bus.cpu_ready}, 32'd1);
        chk("er_data", bus.cpu_rdata, ref_mem[12'h08C >> 2]);
`ifdef EARLY_RESTART_EN
        chk("er_lat", lat, 7);
        chk("er_midburst", {31'd0, burst_active}, 32'd1);
`else
        chk("er_lat", lat, 20);
`endif
        bus.cpu_addr = 12'h080;
        lat = 0;
        do begin @(posedge clock); #1; lat++; end
        while (!bus.cpu_ready && lat < 300);
        chk("er_next_ready", {31'd0, bus.cpu_ready}, 32'd1);
        chk("er_next_data", bus.cpu_rdata, ref_mem[12'h080 >> 2]);
        chk("er_fill_done", {31'd0, burst_active}, 32'd0);
        bus.cpu_req = 1'b0;
        @(posedge clock); #1;
        chk("er_rdcnt", rd_count - rd0, 1);
        cached_base = 32'h080;
        settle();
        do_access(1'b0, 12'h0BC, 32'h0, "hit_0bc", lat);

        chk("protocol", prot_err, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
